// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the shared-datapath RISC-V core.
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to trap on unrecognised opcodes.
module mc_controller #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 memReady,
  output logic [1:0]           immSrc,
  output logic [1:0]           aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic [1:0]           resultSrc,
  output logic [2:0]           aluControl,
  output logic                 adrSrc,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic                 memWrite,
  output logic                 regWrite,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [INSTRET_W-1:0]   r_instret;
  logic [2:0]             w_r_alu;
  logic                   w_ir_write;
  logic                   w_pc_write;
  logic                   w_mem_write;
  logic                   w_reg_write;

  always_comb begin
    unique case (op)
      OP_STORE: immSrc = 2'b01;
      OP_BR:    immSrc = 2'b10;
      OP_JAL:   immSrc = 2'b11;
      default:  immSrc = 2'b00;
    endcase
  end

  // ALU operation for register and immediate arithmetic; only R-type may subtract.
  always_comb begin
    unique case (funct3)
      3'b000:  w_r_alu = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  w_r_alu = ALU_SLT;
      3'b110:  w_r_alu = ALU_OR;
      3'b111:  w_r_alu = ALU_AND;
      default: w_r_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    w_next      = r_state;
    aluSrcA     = 2'b00;
    aluSrcB     = 2'b00;
    resultSrc   = 2'b00;
    aluControl  = ALU_ADD;
    adrSrc      = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        aluSrcB    = 2'b10;
        resultSrc  = 2'b10;
        w_ir_write = memReady;
        w_pc_write = memReady;
        if (memReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_BR:             w_next = S_BEQ;
          OP_JAL:            w_next = S_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:           w_next = S_TRAP;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
        if (memReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc   = 2'b01;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc      = 1'b1;
        w_mem_write = 1'b1;
        if (memReady) w_next = S_FETCH;
      end
      S_EXECR: begin
        aluSrcA    = 2'b10;
        aluControl = w_r_alu;
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA    = 2'b10;
        aluSrcB    = 2'b01;
        aluControl = w_r_alu;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        aluSrcA    = 2'b10;
        aluControl = ALU_SUB;
        w_pc_write = zero;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        aluSrcA    = 2'b01;
        aluSrcB    = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: w_next = S_TRAP;
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are masked while reset is asserted; state is already FETCH then.
  assign irWrite  = rst_n & w_ir_write;
  assign pcWrite  = rst_n & w_pc_write;
  assign memWrite = rst_n & w_mem_write;
  assign regWrite = rst_n & w_reg_write;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != S_FETCH && w_next == S_FETCH) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  assign instret = r_instret;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else if (r_state == S_DECODE && w_next == S_TRAP) r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule
